// File: rtl/led_time_share.sv
// rtl/led_time_share.sv - round-robin time sharing of one blink LED, held off until PLL lock settles
module led_time_share #(
  parameter int NUM_REQ           = 4,
  parameter int TICK_DIV          = 16000,
  parameter int SLICE_TICKS       = 2000,
  parameter int LOCK_SETTLE_TICKS = 10,
  parameter int HP_W              = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*HP_W-1:0] half_period,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    led,
  output logic                    ready
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SLICE_TICKS + 1);
  localparam int LW = $clog2(LOCK_SETTLE_TICKS + 1);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLICE_LAST  = SW'(SLICE_TICKS - 1);
  localparam logic [LW-1:0] SETTLE_LAST = LW'(LOCK_SETTLE_TICKS - 1);
  localparam logic [IW-1:0] RR_INIT     = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    IDLE,
    SERVE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                led_q, led_d;
  logic                ready_q, ready_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [LW-1:0]       settle_q, settle_d;
  logic [SW-1:0]       slice_q, slice_d;
  logic [HP_W-1:0]     phase_q, phase_d;
  logic [IW-1:0]       rr_q, rr_d;

  logic                tick;
  logic                arb_any;
  logic [IW-1:0]       arb_idx;
  logic [NUM_REQ-1:0]  arb_onehot;
  logic [HP_W-1:0]     hp_raw;
  logic [HP_W-1:0]     hp_eff;
  logic [HP_W:0]       phase_inc;
  logic                phase_hit;
  logic                slice_end;

  assign tick = (presc_q == PRESC_LAST);

  // Walk downward so the lowest offset from rr+1 is the last, and winning, assignment.
  always_comb begin
    int idx;
    idx     = 0;
    arb_any = 1'b0;
    arb_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (req[IW'(idx)]) begin
        arb_any = 1'b1;
        arb_idx = IW'(idx);
      end
    end
  end

  assign arb_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;

  assign hp_raw    = half_period[rr_q*HP_W +: HP_W];
  assign hp_eff    = (hp_raw == '0) ? {{(HP_W-1){1'b0}}, 1'b1} : hp_raw;
  assign phase_inc = {1'b0, phase_q} + {{HP_W{1'b0}}, 1'b1};
  assign phase_hit = (phase_inc >= {1'b0, hp_eff});

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    led_d     = led_q;
    ready_d   = ready_q;
    settle_d  = settle_q;
    slice_d   = slice_q;
    phase_d   = phase_q;
    rr_d      = rr_q;
    slice_end = 1'b0;
    presc_d   = tick ? '0 : presc_q + PW'(1);

    if (!pll_locked) begin
      state_d  = WAIT_LOCK;
      grant_d  = '0;
      led_d    = 1'b0;
      ready_d  = 1'b0;
      settle_d = '0;
      slice_d  = '0;
      phase_d  = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          grant_d = '0;
          led_d   = 1'b0;
          ready_d = 1'b0;
          if (tick) begin
            settle_d = settle_q + LW'(1);
            if (settle_q == SETTLE_LAST) begin
              ready_d = 1'b1;
              state_d = IDLE;
            end
          end
        end

        IDLE: begin
          if (arb_any) begin
            grant_d = arb_onehot;
            rr_d    = arb_idx;
            led_d   = 1'b1;
            slice_d = '0;
            phase_d = '0;
            state_d = SERVE;
          end
        end

        SERVE: begin
          slice_end = !req[rr_q] || (tick && (slice_q == SLICE_LAST));
          if (tick) begin
            slice_d = slice_q + SW'(1);
            if (phase_hit) begin
              phase_d = '0;
              led_d   = ~led_q;
            end else begin
              phase_d = phase_inc[HP_W-1:0];
            end
          end
          // A sole requester keeps its blink phase; only the slice restarts.
          if (slice_end) begin
            if (!arb_any) begin
              state_d = IDLE;
              grant_d = '0;
              led_d   = 1'b0;
              slice_d = '0;
              phase_d = '0;
            end else if (arb_idx != rr_q) begin
              grant_d = arb_onehot;
              rr_d    = arb_idx;
              led_d   = 1'b1;
              slice_d = '0;
              phase_d = '0;
            end else begin
              slice_d = '0;
            end
          end
        end

        default: begin
          state_d = WAIT_LOCK;
          grant_d = '0;
          led_d   = 1'b0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      grant_q  <= '0;
      led_q    <= 1'b0;
      ready_q  <= 1'b0;
      presc_q  <= '0;
      settle_q <= '0;
      slice_q  <= '0;
      phase_q  <= '0;
      rr_q     <= RR_INIT;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      led_q    <= led_d;
      ready_q  <= ready_d;
      presc_q  <= presc_d;
      settle_q <= settle_d;
      slice_q  <= slice_d;
      phase_q  <= phase_d;
      rr_q     <= rr_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign ready = ready_q;

endmodule

// File: doc/led_time_share.md
Name: led_time_share

Overview:
- Shares the single board LED between NUM_REQ requesters.
- Each requester wants the LED to blink at its own half-period.
- Grants the LED round-robin in fixed time slices, derived from the PLL-generated core clock.
- Holds everything off until the PLL lock indication has been stable for a settle interval.
- Sits between the PLL and the LED pin, replacing a free-running blink divider.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_DIV, 16000, core clocks per tick (1 ms at 16 MHz); range 2..2^24.
- SLICE_TICKS, 2000, ticks per grant slice; must be >=1.
- LOCK_SETTLE_TICKS, 10, consecutive ticks pll_locked must stay high before service starts; must be >=1.
- HP_W, 16, width of each half-period field (ticks).

Ports:
- clk  in  1  core clock (PLL output)
- reset  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL LOCK output; treated as synchronous to clk
- req  in  NUM_REQ  request level, bit i = requester i
- half_period  in  NUM_REQ*HP_W  requester i half-period in ticks, bits [i*HP_W +: HP_W]
- grant  out  NUM_REQ  one-hot owner of LED, all-zero when none
- led  out  1  LED drive
- ready  out  1  high once lock has settled

Behaviour:
- Reset (async, active-high) forces the following; all outputs and counters are registered:
  - state=WAIT_LOCK, grant=0, led=0, ready=0.
  - tick prescaler=0, settle counter=0, slice counter=0, phase counter=0.
  - rr pointer=NUM_REQ-1, so requester 0 has priority first.
- Tick: prescaler counts 0..TICK_DIV-1 continuously, in every state; tick pulses one cycle when it wraps.
- WAIT_LOCK:
  - pll_locked low clears the settle counter.
  - Each tick with pll_locked high increments the settle counter.
  - When it reaches LOCK_SETTLE_TICKS: ready=1 next cycle, go to IDLE.
- Any state, pll_locked low on a clock edge → next cycle:
  - state=WAIT_LOCK, grant=0, led=0, ready=0, settle counter=0.
  - This has priority over all other events.
- IDLE, arbitration:
  - If any req bit is high, pick the first set bit searching upward from rr+1 modulo NUM_REQ.
  - Next cycle: grant=onehot(winner), rr=winner, led=1, slice counter=0, phase counter=0, state=SERVE.
  - Latency is one clock from req edge to grant.
- SERVE, per tick:
  - Increment slice counter and phase counter.
  - Effective half-period hp = max(half_period[owner],1); the field is sampled live each tick.
  - When phase counter reaches hp: toggle led, phase counter=0.
- SERVE, slice end. Triggered either by req[owner] low (checked every cycle, not only on ticks) or by the slice counter reaching SLICE_TICKS on a tick. Then, next cycle:
  - Re-arbitrate exactly as in IDLE, excluding nothing.
  - If the winner is a different requester: new grant, led=1, counters cleared.
  - If the winner is the same owner (sole requester): grant unchanged, slice counter=0, led and phase counter continue uninterrupted (no glitch).
  - If no requests: grant=0, led=0, state=IDLE.
- Simultaneous events in one cycle:
  - pll_locked low beats slice end.
  - Slice end beats a phase toggle; the toggle is dropped and the new owner starts at led=1.
- grant is always one-hot or zero; no cycle has two bits set.
- Counters saturate-free: widths are sized so that SLICE_TICKS, LOCK_SETTLE_TICKS and 2^HP_W-1 fit without overflow.

Test Plan:
(Bench parameters: TICK_DIV=4, SLICE_TICKS=8, LOCK_SETTLE_TICKS=3, NUM_REQ=4.)
- Lock settle: assert reset, release; pll_locked high for 2 ticks, low 1 cycle, then high → ready rises exactly 3 ticks after the final rise; grant=0 and led=0 throughout.
- Single requester: req=0001, half_period0=2 → grant=0001 one clock later, led=1. led toggles every 8 clocks. At slice end grant stays 0001 with no led glitch.
- Round robin: req=1011 held → grant sequence 0001,0010,1000,0001, each lasting 32 clocks; led=1 at each owner change.
- Early release: owner 1 drops req mid-slice with req2 pending → grant=0100 next cycle. With nothing else pending → grant=0, led=0, IDLE.
- Lock loss mid-service: pll_locked low while grant=0010 → next cycle grant=0, led=0, ready=0. After relock and 3 ticks, service resumes from rr+1 = requester 2.
- half_period=0 → treated as 1: led toggles every tick (4 clocks). Async reset mid-SERVE clears all outputs in the same cycle, without waiting for a clock edge.
